// File: rtl/pipe_ctrl_if.sv
// Control bundle between the hazard/sequencing controller and the pipeline.
// The master side is the controller; the slave side is the pipeline datapath.
interface pipe_ctrl_if;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        rd_reg1_flag;
  logic        rd_reg2_flag;
  logic        ex_is_load;
  logic        ex_wr_reg_en;
  logic [4:0]  ex_wr_reg_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        md_req;
  logic        md_done;

  logic        stall_pc;
  logic        stall_de;
  logic        stall_ex;
  logic        flush_de;
  logic        flush_ex;
  logic        flush_mem;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        md_start;
  logic        md_abort;
  logic        md_timeout;
  logic [31:0] stall_cnt;

  modport master (
    input  rd_addr1, rd_addr2, rd_reg1_flag, rd_reg2_flag,
    input  ex_is_load, ex_wr_reg_en, ex_wr_reg_addr,
    input  jump_flag, jump_addr, md_req, md_done,
    output stall_pc, stall_de, stall_ex, flush_de, flush_ex, flush_mem,
    output pc_redirect, redirect_pc, md_start, md_abort, md_timeout, stall_cnt
  );

  modport slave (
    output rd_addr1, rd_addr2, rd_reg1_flag, rd_reg2_flag,
    output ex_is_load, ex_wr_reg_en, ex_wr_reg_addr,
    output jump_flag, jump_addr, md_req, md_done,
    input  stall_pc, stall_de, stall_ex, flush_de, flush_ex, flush_mem,
    input  pc_redirect, redirect_pc, md_start, md_abort, md_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller: load-use stalls, fetch redirect,
// mul/div sequencing with timeout abort, and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int MD_MAX_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);

  localparam int CW = $clog2(MD_MAX_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_MAX_CYCLES - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] busy_cnt;
  logic [CW-1:0] busy_cnt_nxt;
  logic          timeout_r;
  logic          timeout_set;
  logic [31:0]   stall_cnt_r;
  logic          hz;

  // x0 is never a real dependency, so a load targeting it cannot hazard.
  assign hz = bus.ex_is_load && bus.ex_wr_reg_en && (bus.ex_wr_reg_addr != 5'd0) &&
              ((bus.rd_reg1_flag && (bus.rd_addr1 == bus.ex_wr_reg_addr)) ||
               (bus.rd_reg2_flag && (bus.rd_addr2 == bus.ex_wr_reg_addr)));

  always_comb begin
    bus.stall_pc    = 1'b0;
    bus.stall_de    = 1'b0;
    bus.stall_ex    = 1'b0;
    bus.flush_de    = 1'b0;
    bus.flush_ex    = 1'b0;
    bus.flush_mem   = 1'b0;
    bus.pc_redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.md_start    = 1'b0;
    bus.md_abort    = 1'b0;
    state_nxt       = state;
    busy_cnt_nxt    = busy_cnt;
    timeout_set     = 1'b0;

    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.md_req) begin
            bus.md_start  = 1'b1;
            bus.stall_pc  = 1'b1;
            bus.stall_de  = 1'b1;
            bus.stall_ex  = 1'b1;
            bus.flush_mem = 1'b1;
            state_nxt     = MD_BUSY;
            busy_cnt_nxt  = CW'(1);
          end else if (bus.jump_flag) begin
            // The hazarding instruction is on the wrong path, so no stall.
            bus.pc_redirect = 1'b1;
            bus.redirect_pc = bus.jump_addr;
            bus.flush_de    = 1'b1;
            bus.flush_ex    = 1'b1;
          end else if (hz) begin
            bus.stall_pc = 1'b1;
            bus.stall_de = 1'b1;
            bus.flush_ex = 1'b1;
          end
        end
        MD_BUSY: begin
          if (bus.md_done) begin
            state_nxt    = IDLE;
            busy_cnt_nxt = '0;
          end else if (busy_cnt == CNT_LAST) begin
            bus.md_abort  = 1'b1;
            bus.flush_mem = 1'b1;
            timeout_set   = 1'b1;
            state_nxt     = IDLE;
            busy_cnt_nxt  = '0;
          end else begin
            bus.stall_pc  = 1'b1;
            bus.stall_de  = 1'b1;
            bus.stall_ex  = 1'b1;
            bus.flush_mem = 1'b1;
            busy_cnt_nxt  = busy_cnt + CW'(1);
          end
        end
        default: begin
          state_nxt    = IDLE;
          busy_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Timeout flag is sticky until reset; the stall counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy_cnt    <= '0;
      timeout_r   <= 1'b0;
      stall_cnt_r <= 32'd0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      if (timeout_set)
        timeout_r <= 1'b1;
      if (bus.stall_pc && (stall_cnt_r != 32'hFFFF_FFFF))
        stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign bus.md_timeout = timeout_r;
  assign bus.stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver issues directed and random cycles and
// queues the reference model's expectations; a monitor pops and compares them.
module tb_pipe_ctrl;

  localparam int MAXC = 8;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        rd_reg1_flag;
    logic        rd_reg2_flag;
    logic        ex_is_load;
    logic        ex_wr_reg_en;
    logic [4:0]  ex_wr_reg_addr;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        md_req;
    logic        md_done;
  } stim_t;

  typedef struct packed {
    logic        stall_pc;
    logic        stall_de;
    logic        stall_ex;
    logic        flush_de;
    logic        flush_ex;
    logic        flush_mem;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        md_start;
    logic        md_abort;
    logic        md_timeout;
    logic [31:0] stall_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.MD_MAX_CYCLES(MAXC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   driverDone = 0;

  // Reference model: cycles elapsed in the current mul/div op (0 = none in flight).
  int          mdElapsed = 0;
  logic        mTimeout  = 1'b0;
  logic [31:0] mCnt      = 32'd0;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t hazardStim(input logic [4:0] r);
    stim_t s;
    s = '0;
    s.ex_is_load     = 1'b1;
    s.ex_wr_reg_en   = 1'b1;
    s.ex_wr_reg_addr = r;
    s.rd_addr1       = r;
    s.rd_reg1_flag   = 1'b1;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic hzm;
    bus.rd_addr1       = s.rd_addr1;
    bus.rd_addr2       = s.rd_addr2;
    bus.rd_reg1_flag   = s.rd_reg1_flag;
    bus.rd_reg2_flag   = s.rd_reg2_flag;
    bus.ex_is_load     = s.ex_is_load;
    bus.ex_wr_reg_en   = s.ex_wr_reg_en;
    bus.ex_wr_reg_addr = s.ex_wr_reg_addr;
    bus.jump_flag      = s.jump_flag;
    bus.jump_addr      = s.jump_addr;
    bus.md_req         = s.md_req;
    bus.md_done        = s.md_done;
    rst                = s.rst;

    hzm = s.ex_is_load && s.ex_wr_reg_en && (s.ex_wr_reg_addr != 0) &&
          ((s.rd_reg1_flag && s.rd_addr1 == s.ex_wr_reg_addr) ||
           (s.rd_reg2_flag && s.rd_addr2 == s.ex_wr_reg_addr));
    e = '0;
    e.md_timeout = mTimeout;
    e.stall_cnt  = mCnt;
    if (!s.rst) begin
      if (mdElapsed == 0) begin
        if (s.md_req) begin
          e.md_start = 1; e.stall_pc = 1; e.stall_de = 1; e.stall_ex = 1; e.flush_mem = 1;
        end else if (s.jump_flag) begin
          e.pc_redirect = 1; e.redirect_pc = s.jump_addr; e.flush_de = 1; e.flush_ex = 1;
        end else if (hzm) begin
          e.stall_pc = 1; e.stall_de = 1; e.flush_ex = 1;
        end
      end else if (!s.md_done) begin
        if (mdElapsed == MAXC - 1) begin
          e.md_abort = 1; e.flush_mem = 1;
        end else begin
          e.stall_pc = 1; e.stall_de = 1; e.stall_ex = 1; e.flush_mem = 1;
        end
      end
    end
    expQ.push_back(e);

    if (s.rst) begin
      mdElapsed = 0;
      mTimeout  = 1'b0;
      mCnt      = 32'd0;
    end else begin
      if (e.stall_pc && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
      if (mdElapsed == 0) begin
        if (s.md_req) mdElapsed = 1;
      end else if (s.md_done) begin
        mdElapsed = 0;
      end else if (mdElapsed == MAXC - 1) begin
        mdElapsed = 0;
        mTimeout  = 1'b1;
      end else begin
        mdElapsed = mdElapsed + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("stall_pc",    {31'd0, bus.stall_pc},    {31'd0, e.stall_pc});
    cmp("stall_de",    {31'd0, bus.stall_de},    {31'd0, e.stall_de});
    cmp("stall_ex",    {31'd0, bus.stall_ex},    {31'd0, e.stall_ex});
    cmp("flush_de",    {31'd0, bus.flush_de},    {31'd0, e.flush_de});
    cmp("flush_ex",    {31'd0, bus.flush_ex},    {31'd0, e.flush_ex});
    cmp("flush_mem",   {31'd0, bus.flush_mem},   {31'd0, e.flush_mem});
    cmp("pc_redirect", {31'd0, bus.pc_redirect}, {31'd0, e.pc_redirect});
    cmp("redirect_pc", bus.redirect_pc,          e.redirect_pc);
    cmp("md_start",    {31'd0, bus.md_start},    {31'd0, e.md_start});
    cmp("md_abort",    {31'd0, bus.md_abort},    {31'd0, e.md_abort});
    cmp("md_timeout",  {31'd0, bus.md_timeout},  {31'd0, e.md_timeout});
    cmp("stall_cnt",   bus.stall_cnt,            e.stall_cnt);
  endtask

  // Monitor: outputs are combinational, so every falling edge presents a result.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    stim_t s;
    bus.rd_addr1 = 0; bus.rd_addr2 = 0; bus.rd_reg1_flag = 0; bus.rd_reg2_flag = 0;
    bus.ex_is_load = 0; bus.ex_wr_reg_en = 0; bus.ex_wr_reg_addr = 0;
    bus.jump_flag = 0; bus.jump_addr = 0; bus.md_req = 0; bus.md_done = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());

    applyStimulus(hazardStim(5'd5));
    s = hazardStim(5'd5); s.rd_reg1_flag = 1'b0;
    applyStimulus(s);
    applyStimulus(hazardStim(5'd0));
    s = hazardStim(5'd7); s.rd_reg1_flag = 1'b0; s.rd_addr2 = 5'd7; s.rd_reg2_flag = 1'b1;
    applyStimulus(s);

    s = hazardStim(5'd5); s.jump_flag = 1'b1; s.jump_addr = 32'h0000_0120;
    applyStimulus(s);

    s = idleStim(); s.md_req = 1'b1; s.jump_flag = 1'b1; s.jump_addr = 32'hDEAD_0000;
    applyStimulus(s);
    for (int i = 1; i < 4; i++) begin
      s = hazardStim(5'd3); s.jump_flag = 1'b1;
      applyStimulus(s);
    end
    s = idleStim(); s.md_done = 1'b1;
    applyStimulus(s);
    s = idleStim(); s.md_req = 1'b1;
    applyStimulus(s);
    s = idleStim(); s.md_done = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    s = idleStim(); s.md_req = 1'b1;
    applyStimulus(s);
    for (int i = 1; i <= MAXC; i++) applyStimulus(idleStim());
    applyStimulus(idleStim());

    s = idleStim(); s.md_req = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());
    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());

    force dut.stall_cnt_r = 32'hFFFF_FFFC;
    #1;
    release dut.stall_cnt_r;
    mCnt = 32'hFFFF_FFFC;
    for (int i = 0; i < 7; i++) applyStimulus(hazardStim(5'd9));
    applyStimulus(idleStim());

    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.rst            = ($urandom_range(0, 59) == 0);
      s.rd_addr1       = 5'($urandom_range(0, 3));
      s.rd_addr2       = 5'($urandom_range(0, 3));
      s.rd_reg1_flag   = 1'($urandom_range(0, 1));
      s.rd_reg2_flag   = 1'($urandom_range(0, 1));
      s.ex_is_load     = 1'($urandom_range(0, 1));
      s.ex_wr_reg_en   = 1'($urandom_range(0, 1));
      s.ex_wr_reg_addr = 5'($urandom_range(0, 3));
      s.jump_flag      = ($urandom_range(0, 3) == 0);
      s.jump_addr      = $urandom;
      s.md_req         = ($urandom_range(0, 4) == 0);
      s.md_done        = ($urandom_range(0, 5) == 0);
      applyStimulus(s);
    end

    driverDone = 1;
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d results never observed, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, driverDone=%0d expected 1", driverDone);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
